dac_frame_rx: RTL and testbench



---
 rtl/dac_frame_pkg.sv | 32 +++
 rtl/spi_edge_sync.sv | 33 +++
 rtl/dac_frame_rx.sv | 186 ++++++++++++++++++
 tb/tb_dac_frame_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_frame_pkg.sv
// Shared definitions for the DAC SPI frame receiver: command codes, frame field
// positions, receive FSM encoding and the channel-select helper.
package dac_frame_pkg;

    localparam logic [3:0] CMD_WRITE         = 4'b0000;
    localparam logic [3:0] CMD_UPDATE        = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'b0010;
    localparam logic [3:0] CMD_WRITE_UPD     = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN    = 4'b0100;
    localparam logic [3:0] CMD_NOP           = 4'b1111;

    localparam logic [3:0] CH_ALL = 4'hF;

    localparam int DATA_LSB = 16;
    localparam int CH_LSB   = 12;
    localparam int CH_W     = 4;
    localparam int CMD_LSB  = 8;
    localparam int CMD_W    = 4;

    localparam logic [5:0] CNT_MAX = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } frame_state_t;

    function automatic logic ch_selected(input logic [3:0] ch, input int n);
        return (ch == CH_ALL) || (ch == 4'(n));
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for one SPI pin with rise/fall pulse generation.
// IDLE_LEVEL sets the reset value so an idle-high pin produces no edge after reset.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_r <= IDLE_LEVEL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level = sync_r[SYNC_STAGES-1];
    assign rise  = level & ~prev_r;
    assign fall  = ~level & prev_r;

endmodule

// File: rtl/dac_frame_rx.sv
// SPI slave receiver and behavioural 4-channel DAC model (input/output registers, power-down).
// Optional echo of the previous frame on spi_miso: define DAC_FRAME_RX_ECHO_EN.
module dac_frame_rx
    import dac_frame_pkg::*;
#(
    parameter int FRAME_BITS  = 32,
    parameter int DATA_W      = 12,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  dac_cs,
    input  logic                  dac_clr,
    output logic                  spi_miso,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [DATA_W-1:0]     rx_data,
    output logic [3:0]            rx_channel,
    output logic [3:0]            rx_command,
    output logic [NCH*DATA_W-1:0] dac_value,
    output logic [NCH-1:0]        dac_pd
);

    localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);

    logic sck_level_s, sck_rise_s, sck_fall_s;
    logic mosi_level_s, mosi_rise_s, mosi_fall_s;
    logic cs_level_s, cs_rise_s, cs_fall_s;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(spi_sck),
        .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s));
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(mosi_level_s), .rise(mosi_rise_s), .fall(mosi_fall_s));
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(dac_cs),
        .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s));

    frame_state_t                   state_r, state_s;
    logic [5:0]                     bit_cnt_r;
    logic [FRAME_BITS-1:0]          sr_r;
    logic [NCH-1:0][DATA_W-1:0]     in_r, out_r;
    logic [NCH-1:0]                 pd_r;
    logic                           frame_valid_r, frame_err_r;
    logic [DATA_W-1:0]              rx_data_r;
    logic [3:0]                     rx_channel_r, rx_command_r;
    logic [NCH-1:0]                 sel_s, wr_s, upd_s, pdset_s;
    logic                           dec_ok_s;
    logic [DATA_W-1:0]              f_data_s;
    logic [3:0]                     f_ch_s, f_cmd_s;

    assign f_data_s = sr_r[DATA_LSB +: DATA_W];
    assign f_ch_s   = sr_r[CH_LSB +: CH_W];
    assign f_cmd_s  = sr_r[CMD_LSB +: CMD_W];
    assign dec_ok_s = (state_r == ST_DECODE) && (bit_cnt_r == FRAME_CNT);

    // Next-state logic; IDLE follows the cs level so a fall during DECODE is not lost
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   if (!cs_level_s) state_s = ST_SHIFT;  else state_s = ST_IDLE;
            ST_SHIFT:  if (cs_rise_s)   state_s = ST_DECODE; else state_s = ST_SHIFT;
            ST_DECODE: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register, bit counter and input shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 6'd0;
            sr_r      <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && (state_s == ST_SHIFT)) begin
                bit_cnt_r <= 6'd0;
            end else if ((state_r == ST_SHIFT) && sck_rise_s && !cs_level_s) begin
                sr_r <= {sr_r[FRAME_BITS-2:0], mosi_level_s};
                if (bit_cnt_r != CNT_MAX) bit_cnt_r <= bit_cnt_r + 6'd1;
            end
        end
    end

    // Per-channel write/update/power-down masks for a well-formed frame
    always_comb begin
        wr_s    = '0;
        upd_s   = '0;
        pdset_s = '0;
        for (int n = 0; n < NCH; n++) sel_s[n] = ch_selected(f_ch_s, n);
        if (dec_ok_s) begin
            case (f_cmd_s)
                CMD_WRITE:         wr_s = sel_s;
                CMD_UPDATE:        upd_s = sel_s;
                CMD_WRITE_UPD_ALL: begin wr_s = sel_s; upd_s = {NCH{|sel_s}}; end
                CMD_WRITE_UPD:     begin wr_s = sel_s; upd_s = sel_s; end
                CMD_POWER_DOWN:    pdset_s = sel_s;
                CMD_NOP:           pdset_s = '0;
                default:           pdset_s = '0;
            endcase
        end else begin
            pdset_s = '0;
        end
    end

    // DAC register file; dac_clr wins over any coincident command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r  <= '0;
            out_r <= '0;
            pd_r  <= '0;
        end else if (!dac_clr) begin
            in_r  <= '0;
            out_r <= '0;
            pd_r  <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (wr_s[n])  in_r[n]  <= f_data_s;
                if (upd_s[n]) out_r[n] <= wr_s[n] ? f_data_s : in_r[n];
                if (upd_s[n]) pd_r[n] <= 1'b0;
                else if (pdset_s[n]) pd_r[n] <= 1'b1;
            end
        end
    end

    // Frame status pulses and latched fields of the last valid frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            rx_data_r     <= '0;
            rx_channel_r  <= 4'd0;
            rx_command_r  <= 4'd0;
        end else begin
            frame_valid_r <= dec_ok_s;
            frame_err_r   <= (state_r == ST_DECODE) && (bit_cnt_r != FRAME_CNT);
            if (dec_ok_s) begin
                rx_data_r    <= f_data_s;
                rx_channel_r <= f_ch_s;
                rx_command_r <= f_cmd_s;
            end
        end
    end

    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign rx_data     = rx_data_r;
    assign rx_channel  = rx_channel_r;
    assign rx_command  = rx_command_r;
    assign dac_value   = out_r;
    assign dac_pd      = pd_r;

`ifdef DAC_FRAME_RX_ECHO_EN
    logic [FRAME_BITS-1:0] last_frame_r, echo_sr_r;
    logic                  unused_s;

    // Capture every completed frame and shift it out on the following one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_frame_r <= '0;
            echo_sr_r    <= '0;
        end else begin
            if (state_r == ST_DECODE) last_frame_r <= sr_r;
            if ((state_r == ST_IDLE) && !cs_level_s) begin
                echo_sr_r <= last_frame_r;
            end else if (!cs_level_s && sck_fall_s) begin
                echo_sr_r <= {echo_sr_r[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign spi_miso = echo_sr_r[FRAME_BITS-1];
    assign unused_s = ^{cs_fall_s, sck_level_s, mosi_rise_s, mosi_fall_s};
`else
    logic unused_s;

    assign spi_miso = 1'b0;
    assign unused_s = ^{cs_fall_s, sck_level_s, sck_fall_s, mosi_rise_s, mosi_fall_s,
                        sr_r[FRAME_BITS-1:DATA_LSB+DATA_W], sr_r[CMD_LSB-1:0]};
`endif

endmodule

// File: tb/tb_dac_frame_rx.sv
// Self-checking bench for dac_frame_rx: frames are driven bit-serially, a procedural DAC
// model produces expectations that are queued per frame and compared on the status pulse.
module tb_dac_frame_rx;

    logic        clk, rst, spi_sck, spi_mosi, dac_cs, dac_clr;
    logic        spi_miso, frame_valid, frame_err;
    logic [11:0] rx_data;
    logic [3:0]  rx_channel, rx_command;
    logic [47:0] dac_value;
    logic [3:0]  dac_pd;

    dac_frame_rx dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .dac_cs(dac_cs), .dac_clr(dac_clr), .spi_miso(spi_miso),
        .frame_valid(frame_valid), .frame_err(frame_err), .rx_data(rx_data),
        .rx_channel(rx_channel), .rx_command(rx_command),
        .dac_value(dac_value), .dac_pd(dac_pd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_valid;
        logic [47:0] dac;
        logic [3:0]  pd;
        logic [11:0] data;
        logic [3:0]  ch;
        logic [3:0]  cmd;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] m_in [4];
    logic [11:0] m_out[4];
    logic [3:0]  m_pd;
    logic [11:0] m_data;
    logic [3:0]  m_ch, m_cmd;
    logic [31:0] miso_word;

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin m_in[n] = 12'h0; m_out[n] = 12'h0; end
        m_pd = 4'h0; m_data = 12'h0; m_ch = 4'h0; m_cmd = 4'h0;
    endtask

    task automatic model_apply(input logic [31:0] w);
        logic [11:0] d;
        logic [3:0]  c, m;
        d = w[27:16]; c = w[15:12]; m = w[11:8];
        m_data = d; m_ch = c; m_cmd = m;
        for (int n = 0; n < 4; n++) begin
            if (c == 4'hF || c == 4'(n)) begin
                case (m)
                    4'h0: m_in[n] = d;
                    4'h1: begin m_out[n] = m_in[n]; m_pd[n] = 1'b0; end
                    4'h2: m_in[n] = d;
                    4'h3: begin m_in[n] = d; m_out[n] = d; m_pd[n] = 1'b0; end
                    4'h4: m_pd[n] = 1'b1;
                    default: ;
                endcase
            end
        end
        if (m == 4'h2 && (c == 4'hF || c < 4'd4)) begin
            for (int n = 0; n < 4; n++) begin m_out[n] = m_in[n]; m_pd[n] = 1'b0; end
        end
    endtask

    // Drive one frame of nbits sck pulses; optionally hold dac_clr low across DECODE
    task automatic send_frame(input logic [31:0] w, input int nbits, input bit clr);
        exp_t e;
        int   nv, ne;
        @(negedge clk);
        dac_cs = 1'b0;
        miso_word = 32'h0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 32) ? w[31-i] : 1'b0;
            repeat (4) @(negedge clk);
            if (i < 32) miso_word[31-i] = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        dac_cs = 1'b1;
        e.is_valid = (nbits == 32);
        if (nbits == 32) model_apply(w);
        if (clr) begin
            for (int n = 0; n < 4; n++) begin m_in[n] = 12'h0; m_out[n] = 12'h0; end
            m_pd = 4'h0;
        end
        e.dac = {m_out[3], m_out[2], m_out[1], m_out[0]};
        e.pd = m_pd; e.data = m_data; e.ch = m_ch; e.cmd = m_cmd;
        sb.push_back(e);
        nv = 0; ne = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (clr && i == 2) dac_clr = 1'b0;
            if (clr && i == 5) dac_clr = 1'b1;
            if (frame_valid) nv++;
            if (frame_err) ne++;
        end
        vectors++;
        if (nv + ne == 0) begin
            miscompares++;
            $display("FAIL frame %h timeout: no frame_valid/frame_err within 12 clk", w);
            void'(sb.pop_front());
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            if (nv !== (e.is_valid ? 1 : 0) || ne !== (e.is_valid ? 0 : 1)) begin
                miscompares++;
                $display("FAIL frame %h pulses: valid=%0d err=%0d, required valid=%0d err=%0d",
                         w, nv, ne, e.is_valid ? 1 : 0, e.is_valid ? 0 : 1);
            end
            vectors++;
            if (dac_value !== e.dac || dac_pd !== e.pd) begin
                miscompares++;
                $display("FAIL frame %h regs: dac_value=%h pd=%b, required %h pd=%b",
                         w, dac_value, dac_pd, e.dac, e.pd);
            end
            vectors++;
            if (rx_data !== e.data || rx_channel !== e.ch || rx_command !== e.cmd) begin
                miscompares++;
                $display("FAIL frame %h fields: %h/%h/%h, required %h/%h/%h",
                         w, rx_data, rx_channel, rx_command, e.data, e.ch, e.cmd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; dac_cs = 1'b1; dac_clr = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({frame_valid, frame_err, spi_miso} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_pulses: %b, required 000", {frame_valid, frame_err, spi_miso});
        end
        vectors++;
        if (dac_value !== 48'h0 || dac_pd !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_regs: %h pd=%b, required 0", dac_value, dac_pd);
        end
        vectors++;
        if ({rx_data, rx_channel, rx_command} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_fields: %h, required 0", {rx_data, rx_channel, rx_command});
        end
    endtask

    task automatic test_write_update();
        send_frame(32'h0ABC_0300, 32, 1'b0);
        vectors++;
        if (dac_value !== 48'h000_000_000_ABC) begin
            miscompares++;
            $display("FAIL write_update: dac_value=%h, required 000000000abc", dac_value);
        end
    endtask

    task automatic test_broadcast();
        send_frame(32'h0123_F000, 32, 1'b0);
        send_frame(32'h0000_1100, 32, 1'b0);
        vectors++;
        if (dac_value !== {12'h000, 12'h000, 12'h123, 12'hABC}) begin
            miscompares++;
            $display("FAIL broadcast: dac_value=%h, required 000000123abc", dac_value);
        end
    endtask

    task automatic test_bad_count();
        send_frame(32'h0FFF_F300, 31, 1'b0);
        send_frame(32'h0FFF_F300, 33, 1'b0);
        vectors++;
        if (dac_value !== {12'h000, 12'h000, 12'h123, 12'hABC}) begin
            miscompares++;
            $display("FAIL bad_count: dac_value=%h, required 000000123abc", dac_value);
        end
    endtask

    task automatic test_power_down();
        send_frame(32'h0000_2400, 32, 1'b0);
        vectors++;
        if (dac_pd !== 4'b0100) begin
            miscompares++;
            $display("FAIL pd_set: dac_pd=%b, required 0100", dac_pd);
        end
        send_frame(32'h07FF_2300, 32, 1'b0);
        vectors++;
        if (dac_pd !== 4'b0000 || dac_value[35:24] !== 12'h7FF) begin
            miscompares++;
            $display("FAIL pd_clear: dac_pd=%b out2=%h, required 0000 7ff", dac_pd, dac_value[35:24]);
        end
    endtask

    task automatic test_clear();
        send_frame(32'h0FFF_F300, 32, 1'b1);
        vectors++;
        if (dac_value !== 48'h0 || rx_data !== 12'hFFF || dac_clr !== 1'b1) begin
            miscompares++;
            $display("FAIL clear: dac_value=%h rx_data=%h, required 0 fff", dac_value, rx_data);
        end
    endtask

    task automatic test_misc_commands();
        send_frame(32'h0555_5000, 32, 1'b0);
        send_frame(32'h0456_3200, 32, 1'b0);
        vectors++;
        if (dac_value !== {12'h456, 12'h000, 12'h000, 12'h000}) begin
            miscompares++;
            $display("FAIL write_upd_all: dac_value=%h, required 456000000000", dac_value);
        end
        send_frame(32'h0111_0700, 32, 1'b0);
    endtask

    task automatic test_echo();
        send_frame(32'hDEAD_BEEF, 32, 1'b0);
        send_frame(32'h0000_0000, 32, 1'b0);
        vectors++;
`ifdef DAC_FRAME_RX_ECHO_EN
        if (miso_word !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL echo: miso=%h, required deadbeef", miso_word);
        end
`else
        if (miso_word !== 32'h0) begin
            miscompares++;
            $display("FAIL echo_off: miso=%h, required 0", miso_word);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        int nv, ne;
        @(negedge clk);
        dac_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            spi_mosi = i[0];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
        rst = 1'b1; dac_cs = 1'b1; spi_mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        nv = 0; ne = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_valid) nv++;
            if (frame_err) ne++;
        end
        vectors++;
        if (nv != 0 || ne != 0 || dac_value !== 48'h0 || rx_data !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_midframe: valid=%0d err=%0d dac=%h rx=%h, required none/0",
                     nv, ne, dac_value, rx_data);
        end
        send_frame(32'h0ABC_0300, 32, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_update();
        test_broadcast();
        test_bad_count();
        test_power_down();
        test_clear();
        test_misc_commands();
        test_echo();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1);
    end

endmodule
